// File: rtl/ldpc_seq_encoder_if.sv
// Codeword request/response bundle for the sequential LDPC encoder.
// The encoder sits on the slave side; the info-bit source and sink use master.
interface ldpc_seq_encoder_if #(
    parameter int N = 6,
    parameter int K = 3
);
    localparam int M = N - K;

    logic             in_valid;
    logic             in_ready;
    logic [K-1:0]     info_bits;
    logic [K*M-1:0]   gen_p;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     codeword;

    modport slave (
        input  in_valid, info_bits, gen_p, out_ready,
        output in_ready, out_valid, codeword
    );

    modport master (
        output in_valid, info_bits, gen_p, out_ready,
        input  in_ready, out_valid, codeword
    );
endinterface

// File: rtl/ldpc_seq_encoder.sv
// Sequential systematic linear-block encoder: R generator rows per cycle,
// codeword {parity, info} presented from registers over valid/ready.
module ldpc_seq_encoder #(
    parameter int N = 6,
    parameter int K = 3,
    parameter int R = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ldpc_seq_encoder_if.slave    bus,
    output logic                 busy
);
    localparam int M  = N - K;
    localparam int S  = (R > 0) ? K / R : 1;
    localparam int SW = (S > 1) ? $clog2(S) : 1;

    if (N <= K || R < 1 || (K % R) != 0) begin : g_bad_params
        $error("ldpc_seq_encoder: need N > K, R >= 1 and K %% R == 0");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [K-1:0]     info_q, info_d;
    logic [K*M-1:0]   gen_q, gen_d;
    logic [M-1:0]     par_q, par_d;
    logic [SW-1:0]    step_q, step_d;
    logic [N-1:0]     cw_q, cw_d;

    logic [K*M-1:0]   rows;
    logic [K-1:0]     bits;
    logic [M-1:0]     acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            info_q  <= '0;
            gen_q   <= '0;
            par_q   <= '0;
            step_q  <= '0;
            cw_q    <= '0;
        end else begin
            state_q <= state_d;
            info_q  <= info_d;
            gen_q   <= gen_d;
            par_q   <= par_d;
            step_q  <= step_d;
            cw_q    <= cw_d;
        end
    end

    // Shift the current step's rows and info bits down to position 0.
    always_comb begin
        rows = gen_q >> (step_q * R * M);
        bits = info_q >> (step_q * R);
        acc  = par_q;
        for (int r = 0; r < R; r++) begin
            if (bits[r]) begin
                acc = acc ^ rows[r*M +: M];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        info_d  = info_q;
        gen_d   = gen_q;
        par_d   = par_q;
        step_d  = step_q;
        cw_d    = cw_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    info_d  = bus.info_bits;
                    gen_d   = bus.gen_p;
                    par_d   = '0;
                    step_d  = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                par_d  = acc;
                step_d = step_q + 1'b1;
                if (step_q == SW'(S - 1)) begin
                    cw_d    = {acc, info_q};
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.codeword  = cw_q;
    assign busy          = (state_q != IDLE);
endmodule
